// File: rtl/siso_seq_ctrl.sv
// siso_seq_ctrl: serializes a parallel word LSB first into a downstream SISO
// register chain, flushes it through the chain, then pulses done.
// Optional feature: define SISO_SEQ_PARITY_EN to append an even-parity bit
// after the last data bit (SHIFT lasts WIDTH+1 cycles).
// All outputs are registered; they are computed from the next state so they
// line up with the state register rather than lagging it by a cycle.
module siso_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sr_si,
  output logic             sr_shift,
  output logic             sr_clr,
  output logic             busy,
  output logic             done
);

`ifdef SISO_SEQ_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int SHIFT_LEN = WIDTH + PAR_BITS;
  localparam int CNT_MAX   = (SHIFT_LEN > DEPTH + 1) ? SHIFT_LEN : DEPTH + 1;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    DONE
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cntNext;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] wordNext;
  logic [WIDTH-1:0] wordShifted;

  logic inReadyD;
  logic siD;
  logic shiftD;
  logic busyD;
  logic doneD;

  // State, counter, word and registered outputs; clr wins over everything
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      word     <= '0;
      in_ready <= 1'b1;
      sr_si    <= 1'b0;
      sr_shift <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sr_clr   <= 1'b1;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      word     <= wordNext;
      in_ready <= inReadyD;
      sr_si    <= siD;
      sr_shift <= shiftD;
      busy     <= busyD;
      done     <= doneD;
      sr_clr   <= 1'b0;
    end
  end

  // Next state; cnt indexes the bit being driven in SHIFT and the flush cycle in FLUSH
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    wordNext  = word;
    case (state)
      IDLE: begin
        if (in_valid) begin
          wordNext  = in_data;
          cntNext   = '0;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          cntNext   = '0;
          stateNext = FLUSH;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          cntNext   = '0;
          stateNext = DONE;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from next state and next bit index
  always_comb begin
    inReadyD    = (stateNext == IDLE);
    busyD       = (stateNext == SHIFT) || (stateNext == FLUSH);
    shiftD      = busyD;
    doneD       = (stateNext == DONE);
    wordShifted = wordNext >> cntNext;
    siD         = 1'b0;
    if (stateNext == SHIFT) begin
      siD = wordShifted[0];
`ifdef SISO_SEQ_PARITY_EN
      if (cntNext == CW'(WIDTH)) begin
        siD = ^wordNext;
      end
`endif
    end
  end

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// tb_siso_seq_ctrl: scoreboard bench for siso_seq_ctrl. The driver predicts
// acceptance from a timing model and queues the expected serial stream, done
// edge and word; a separate monitor pops and compares as the DUT presents them.
// Honours SISO_SEQ_PARITY_EN the same way as the design.
module tb_siso_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef SISO_SEQ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk;
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sr_si;
  logic             sr_shift;
  logic             sr_clr;
  logic             busy;
  logic             done;

  siso_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .sr_si    (sr_si),
    .sr_shift (sr_shift),
    .sr_clr   (sr_clr),
    .busy     (busy),
    .done     (done)
  );

  int nCompared = 0;
  int nMismatch = 0;
  int cyc = 0;

  bit               expBits[$];
  int               expDone[$];
  logic [WIDTH-1:0] expWord[$];
  bit               rec[$];
  logic [DEPTH:0]   pipe;

  bit modelActive  = 0;
  int accEdge      = 0;
  bit clrSampled   = 1;
  bit pendingClear = 0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at a negedge, cyc is the index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream chain: DEPTH stages plus a registered serial output, records what leaves it
  always @(posedge clk) begin
    if (sr_clr === 1'b1 || done === 1'b1) begin
      rec.delete();
      pipe <= '0;
    end else if (sr_shift === 1'b1) begin
      pipe <= {pipe[DEPTH-1:0], sr_si};
      rec.push_back(pipe[DEPTH-1]);
    end
  end

  // Monitor: compare each presented serial bit and each done pulse against the scoreboard
  always @(negedge clk) begin
    if (sr_shift === 1'b1) begin
      if (expBits.size() == 0) begin
        check("sr_shift_unexpected", 1, 0);
      end else begin
        check("sr_si", int'(sr_si), int'(expBits.pop_front()));
      end
    end
    if (done === 1'b1) begin
      if (expDone.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] e;
        w = '0;
        check("done_edge", cyc + 1, expDone.pop_front());
        e = expWord.pop_front();
        if (rec.size() < DEPTH + WIDTH) begin
          check("chain_len", rec.size(), DEPTH + WIDTH);
        end else begin
          for (int i = 0; i < WIDTH; i++) w[i] = rec[DEPTH + i];
          check("chain_word", int'(w), int'(e));
        end
      end
    end
  end

  function automatic bit modelReady(input int n);
    return !modelActive || (n >= accEdge + WIDTH + DEPTH + 2 + PAR);
  endfunction

  function automatic bit modelBusy(input int n);
    return modelActive && (n >= accEdge) && (n <= accEdge + WIDTH + DEPTH + PAR);
  endfunction

  task automatic checkOutput();
    check("in_ready", int'(in_ready), int'(modelReady(cyc)));
    check("busy", int'(busy), int'(modelBusy(cyc)));
    check("sr_shift_level", int'(sr_shift), int'(modelBusy(cyc)));
    check("sr_clr", int'(sr_clr), int'(clrSampled));
  endtask

  // One cycle: check the current outputs, drive inputs for the next edge, update the model
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit c);
    if (pendingClear) begin
      expBits.delete();
      expDone.delete();
      expWord.delete();
      pendingClear = 0;
    end
    checkOutput();
    in_valid = v;
    in_data  = d;
    clr      = c;
    clrSampled = c;
    if (c) begin
      modelActive  = 0;
      pendingClear = 1;
    end else if (v && modelReady(cyc)) begin
      bit par;
      par = ^d;
      modelActive = 1;
      accEdge     = cyc + 1;
      for (int i = 0; i < WIDTH; i++) expBits.push_back(d[i]);
      if (PAR == 1) expBits.push_back(par);
      for (int i = 0; i < DEPTH + 1; i++) expBits.push_back(1'b0);
      expDone.push_back(accEdge + WIDTH + DEPTH + 2 + PAR);
      expWord.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);

    // Single word A5
    applyStimulus(1, 8'hA5, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 8'h00, 0);

    // Back-to-back: 0F then F0 held high until taken
    applyStimulus(1, 8'h0F, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'hF0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 8'h00, 0);

    // Data changes right after acceptance
    applyStimulus(1, 8'h3C, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'hFF, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0);

    // End-to-end through the chain model
    applyStimulus(1, 8'hC3, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 8'h00, 0);

    // Parity-interesting word
    applyStimulus(1, 8'h07, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 8'h00, 0);

    // Clear held two cycles mid-SHIFT, with in_valid high to test priority
    applyStimulus(1, 8'h5A, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(1, 8'h99, 1);
    applyStimulus(1, 8'h99, 1);
    applyStimulus(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 8'h00, 0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit c;
      logic [WIDTH-1:0] d;
      v = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 79) == 0);
      d = WIDTH'($urandom);
      applyStimulus(v, d, c);
    end

    // Drain with a bounded wait
    for (int i = 0; i < 40 && (expDone.size() != 0 || pendingClear); i++) begin
      applyStimulus(0, 8'h00, 0);
    end
    applyStimulus(0, 8'h00, 0);
    check("drain_done", expDone.size(), 0);
    check("drain_bits", expBits.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
